// File: rtl/snd_fifo_uart_tx_pkg.sv
// Shared constants for the send-FIFO UART drain path: word FSM states,
// default baud divisor and 8N1 frame constants.
package snd_fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    STA_IDLE,
    STA_POP,
    STA_LATCH,
    STA_LOAD,
    STA_WAIT
  } sta_e;

  // 100 MHz system clock / 115200 baud
  localparam int unsigned DEF_CLKS_PER_BIT = 868;

  localparam logic        UART_START_BIT  = 1'b0;
  localparam logic        UART_STOP_BIT   = 1'b1;
  localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/snd_fifo_uart_tx_uart_tx_byte.sv
// 8N1 byte serialiser: registered start, LSB-first data, one-cycle done
// pulse on the final cycle of the stop bit.
module uart_tx_byte
  import snd_fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       done
);

  localparam int unsigned      CNT_W         = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CYC_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_STOP      = 4'(UART_FRAME_BITS - 1);
  localparam logic [3:0]       BIT_LAST_DATA = 4'(UART_FRAME_BITS - 2);

  logic             busy_q, busy_d;
  logic             tx_q, tx_d;
  logic [7:0]       byte_q, byte_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      busy_q <= 1'b0;
      tx_q   <= UART_STOP_BIT;
      byte_q <= '0;
      bit_q  <= '0;
      cyc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tx_q   <= tx_d;
      byte_q <= byte_d;
      bit_q  <= bit_d;
      cyc_q  <= cyc_d;
    end
  end

  // bit_q: 0 = start, 1..8 = data[0..7], 9 = stop
  always_comb begin
    busy_d = busy_q;
    tx_d   = tx_q;
    byte_d = byte_q;
    bit_d  = bit_q;
    cyc_d  = cyc_q;
    done   = 1'b0;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        byte_d = data;
        bit_d  = '0;
        cyc_d  = '0;
        tx_d   = UART_START_BIT;
      end
    end else if (cyc_q == CYC_LAST) begin
      cyc_d = '0;
      if (bit_q == BIT_STOP) begin
        done   = 1'b1;
        busy_d = 1'b0;
        bit_d  = '0;
        tx_d   = UART_STOP_BIT;
      end else begin
        bit_d = bit_q + 4'd1;
        tx_d  = (bit_q == BIT_LAST_DATA) ? UART_STOP_BIT : byte_q[bit_q[2:0]];
      end
    end else begin
      cyc_d = cyc_q + CNT_W'(1);
    end
  end

  assign tx    = tx_q;
  assign ready = !busy_q;

endmodule

// File: rtl/snd_fifo_uart_tx.sv
// Send-FIFO drain: pops 32-bit words and transmits them MSB byte first
// over an 8N1 UART line.
module snd_fifo_uart_tx
  import snd_fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned TCQ          = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        In_enable,
  input  logic [31:0] In_snd_dout,
  input  logic        In_snd_empty,
  output logic        Out_snd_rd_en,
  output logic        Out_tx,
  output logic        Out_busy,
  output logic        Out_word_done
);

  // TCQ remains a parameter so existing instantiations elaborate; no delay is modelled.
  if (TCQ > 0) begin : g_tcq
  end

  sta_e        sta_q, sta_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic        word_done_q, word_done_d;

  logic        byte_start;
  logic [7:0]  byte_sel;
  logic        tx_ready;
  logic        tx_done;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sta_q       <= STA_IDLE;
      word_q      <= '0;
      idx_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      sta_q       <= sta_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      word_done_q <= word_done_d;
    end
  end

  always_comb begin
    sta_d         = sta_q;
    word_d        = word_q;
    idx_d         = idx_q;
    word_done_d   = 1'b0;
    byte_start    = 1'b0;
    Out_snd_rd_en = 1'b0;
    case (sta_q)
      STA_IDLE: begin
        if (In_enable && !In_snd_empty) sta_d = STA_POP;
      end
      STA_POP: begin
        Out_snd_rd_en = 1'b1;
        sta_d         = STA_LATCH;
      end
      STA_LATCH: begin
        word_d = In_snd_dout;
        idx_d  = '0;
        sta_d  = STA_LOAD;
      end
      STA_LOAD: begin
        if (tx_ready) begin
          byte_start = 1'b1;
          sta_d      = STA_WAIT;
        end
      end
      STA_WAIT: begin
        if (tx_done) begin
          if (idx_q == 2'd3) begin
            word_done_d = 1'b1;
            sta_d       = STA_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
            sta_d = STA_LOAD;
          end
        end
      end
      default: sta_d = STA_IDLE;
    endcase
  end

  always_comb begin
    byte_sel = '0;
    case (idx_q)
      2'd0: byte_sel = word_q[31:24];
      2'd1: byte_sel = word_q[23:16];
      2'd2: byte_sel = word_q[15:8];
      2'd3: byte_sel = word_q[7:0];
      default: byte_sel = '0;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .Clk  (Clk),
    .Rst  (Rst),
    .start(byte_start),
    .data (byte_sel),
    .tx   (Out_tx),
    .ready(tx_ready),
    .done (tx_done)
  );

  // word_done_q lands on the first IDLE cycle, the same cycle Out_busy drops
  assign Out_busy      = (sta_q != STA_IDLE);
  assign Out_word_done = word_done_q;

endmodule
